// File: rtl/product_accumulator.sv
// Product accumulator: sums a group of unsigned multiplier products into a
// wide accumulator and presents the group total, beat count and a sticky
// overflow flag through a valid/ready result port.
module product_accumulator #(
  parameter int unsigned SIZE  = 32,
  parameter int unsigned GUARD = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      prod_valid,
  output logic                      prod_ready,
  input  logic [2*SIZE-1:0]         prod_data,
  input  logic                      prod_last,
  output logic                      acc_valid,
  input  logic                      acc_ready,
  output logic [2*SIZE+GUARD-1:0]   acc_data,
  output logic                      acc_overflow,
  output logic [CNT_W-1:0]          acc_count
);

  localparam int unsigned ACC_W = 2 * SIZE + GUARD;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             valid_q;
  // Holds prod_ready low during reset and until the first edge after release.
  logic             en_q;

  logic             beat;
  logic             take;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   sum_add;

  assign prod_ready = en_q && (state_q != HOLD);
  assign beat       = prod_valid && prod_ready;
  assign take       = valid_q && acc_ready;
  assign prod_ext   = ACC_W'(prod_data);
  assign sum_add    = {1'b0, sum_q} + {1'b0, prod_ext};

  // Next-state: clear wins over both handshakes; loads start a fresh group.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat) begin
            sum_d   = prod_ext;
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = prod_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            sum_d   = sum_add[ACC_W-1:0];
            ovf_d   = ovf_q | sum_add[ACC_W];
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = prod_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (take) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and result registers; acc_valid is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= (state_d == HOLD);
      en_q    <= 1'b1;
    end
  end

  assign acc_valid    = valid_q;
  assign acc_data     = sum_q;
  assign acc_overflow = ovf_q;
  assign acc_count    = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed scenarios plus a
// randomly throttled stream checked against a group-level arithmetic model.
module tb_product_accumulator;

  localparam int unsigned SIZE  = 32;
  localparam int unsigned GUARD = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ACC_W = 2 * SIZE + GUARD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             prod_valid = 1'b0;
  logic             prod_ready;
  logic [2*SIZE-1:0] prod_data = '0;
  logic             prod_last = 1'b0;
  logic             acc_valid;
  logic             acc_ready = 1'b0;
  logic [ACC_W-1:0] acc_data;
  logic             acc_overflow;
  logic [CNT_W-1:0] acc_count;

  // Small instance for count saturation and narrow overflow.
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       s_acc_valid;
  logic       s_acc_ready = 1'b0;
  logic [9:0] s_acc_data;
  logic       s_ovf;
  logic [2:0] s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_accumulator #(.SIZE(SIZE), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .prod_valid   (prod_valid),
    .prod_ready   (prod_ready),
    .prod_data    (prod_data),
    .prod_last    (prod_last),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .acc_data     (acc_data),
    .acc_overflow (acc_overflow),
    .acc_count    (acc_count)
  );

  product_accumulator #(.SIZE(4), .GUARD(2), .CNT_W(3)) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (1'b0),
    .prod_valid   (s_valid),
    .prod_ready   (s_ready),
    .prod_data    (s_data),
    .prod_last    (s_last),
    .acc_valid    (s_acc_valid),
    .acc_ready    (s_acc_ready),
    .acc_data     (s_acc_data),
    .acc_overflow (s_ovf),
    .acc_count    (s_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string name, input logic vld, input logic [ACC_W-1:0] dat,
                              input logic ovf, input logic [CNT_W-1:0] cnt);
    checks++;
    if (acc_valid !== vld || acc_data !== dat || acc_overflow !== ovf || acc_count !== cnt) begin
      errors++;
      $display("FAIL %s: got valid=%b data=%h ovf=%b count=%0d, expected valid=%b data=%h ovf=%b count=%0d",
               name, acc_valid, acc_data, acc_overflow, acc_count, vld, dat, ovf, cnt);
    end
  endtask

  task automatic check_ready(input string name, input logic exp);
    checks++;
    if (prod_ready !== exp) begin
      errors++;
      $display("FAIL %s: prod_ready=%b expected %b", name, prod_ready, exp);
    end
  endtask

  task automatic test_reset();
    #2;
    check_result("reset_outputs", 1'b0, '0, 1'b0, '0);
    check_ready("reset_ready_low", 1'b0);
    step();
    step();
    #2 rst_n = 1'b1;
    #1;
    check_ready("ready_before_first_edge", 1'b0);
    step();
    check_ready("ready_after_first_edge", 1'b1);
  endtask

  task automatic test_basic();
    logic [2*SIZE-1:0] vals [3];
    vals[0] = 64'd3; vals[1] = 64'd5; vals[2] = 64'd7;
    acc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prod_valid = 1'b1;
      prod_data  = vals[i];
      prod_last  = (i == 2);
      step();
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("basic_result", 1'b1, 72'd15, 1'b0, 16'd3);
    check_ready("basic_ready_in_hold", 1'b0);
    step();
    check_result("basic_one_cycle", 1'b0, 72'd15, 1'b0, 16'd3);
    check_ready("basic_ready_idle", 1'b1);
  endtask

  task automatic test_hold();
    logic [ACC_W-1:0] exp;
    exp = {8'h00, 64'hFFFF_FFFF_FFFF_FFFF};
    acc_ready  = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    prod_last  = 1'b1;
    step();
    // Keep offering a beat during the hold; it must not be taken.
    prod_data = 64'd1234;
    for (int i = 0; i < 4; i++) begin
      check_result("hold_stable", 1'b1, exp, 1'b0, 16'd1);
      check_ready("hold_ready_low", 1'b0);
      step();
    end
    acc_ready = 1'b1;
    #1;
    check_ready("hold_no_accept_with_ready", 1'b0);
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("hold_released", 1'b0, exp, 1'b0, 16'd1);
    check_ready("hold_back_to_idle", 1'b1);
    step();
    check_result("hold_beat_not_taken", 1'b0, exp, 1'b0, 16'd1);
  endtask

  task automatic test_overflow();
    logic [127:0] tot;
    tot = 128'd257 * 128'hFFFF_FFFF_FFFF_FFFF;
    acc_ready = 1'b0;
    for (int i = 0; i < 257; i++) begin
      prod_valid = 1'b1;
      prod_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      prod_last  = (i == 256);
      step();
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("overflow_wrap", 1'b1, tot[ACC_W-1:0], 1'b1, 16'd257);
    acc_ready = 1'b1;
    step();
    prod_valid = 1'b1;
    prod_data  = 64'd1;
    prod_last  = 1'b1;
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("overflow_cleared_next", 1'b1, 72'd1, 1'b0, 16'd1);
    step();
  endtask

  task automatic test_clear();
    acc_ready = 1'b1;
    prod_valid = 1'b1;
    prod_last  = 1'b0;
    prod_data  = 64'd10;
    step();
    prod_data = 64'd20;
    step();
    clear      = 1'b1;
    prod_data  = 64'd99;
    prod_last  = 1'b1;
    step();
    clear      = 1'b0;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("clear_zeroes", 1'b0, '0, 1'b0, '0);
    check_ready("clear_idle_ready", 1'b1);
    prod_valid = 1'b1;
    prod_data  = 64'd4;
    prod_last  = 1'b1;
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("clear_no_stale", 1'b1, 72'd4, 1'b0, 16'd1);
    // Clear in HOLD drops the result even with acc_ready high.
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_result("clear_in_hold", 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_async_reset_hold();
    acc_ready  = 1'b0;
    prod_valid = 1'b1;
    prod_data  = 64'd77;
    prod_last  = 1'b1;
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("pre_reset_hold", 1'b1, 72'd77, 1'b0, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check_result("async_reset_immediate", 1'b0, '0, 1'b0, '0);
    check_ready("async_reset_ready_low", 1'b0);
    step();
    #2 rst_n = 1'b1;
    step();
    acc_ready  = 1'b1;
    prod_valid = 1'b1;
    prod_data  = 64'd2;
    prod_last  = 1'b0;
    step();
    prod_data = 64'd3;
    prod_last = 1'b1;
    step();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    check_result("after_reset_group", 1'b1, 72'd5, 1'b0, 16'd2);
    step();
  endtask

  task automatic test_count_saturate();
    int sum;
    sum = 0;
    s_acc_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom_range(150, 255));
      sum += int'(s_data);
      s_last  = (i == 9);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (s_acc_valid !== 1'b1 || s_acc_data !== 10'(sum % 1024) || s_ovf !== (sum > 1023)
        || s_cnt !== 3'd7) begin
      errors++;
      $display("FAIL count_saturate: got valid=%b data=%0d ovf=%b count=%0d, expected 1 %0d %b 7",
               s_acc_valid, s_acc_data, s_ovf, s_cnt, sum % 1024, sum > 1023);
    end
    s_acc_ready = 1'b1;
    step();
    s_acc_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [ACC_W-1:0] q_data[$];
    logic             q_ovf[$];
    logic [CNT_W-1:0] q_cnt[$];
    logic [127:0]     m_sum;
    int               m_n;
    bit               open;
    int               beats, groups, results, cycles;
    bit               drain;
    bit               bf, rf;
    m_sum = '0; m_n = 0; open = 0;
    beats = 0; groups = 0; results = 0; cycles = 0; drain = 0;
    forever begin
      if (beats >= 30000) drain = 1;
      if (drain && !open && q_data.size() == 0 && !acc_valid) break;
      if (cycles >= 80000) begin
        errors++;
        checks++;
        $display("FAIL random_timeout: beats=%0d cycles=%0d", beats, cycles);
        break;
      end
      if (drain) begin
        prod_valid = open;
        prod_last  = 1'b1;
        acc_ready  = 1'b1;
      end else begin
        prod_valid = ($urandom_range(0, 3) != 0);
        prod_last  = ($urandom_range(0, 7) == 0);
        acc_ready  = ($urandom_range(0, 3) != 0);
      end
      prod_data = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                               : {$urandom(), $urandom()};
      #3;
      bf = prod_valid && prod_ready;
      rf = acc_valid && acc_ready;
      if (acc_valid) begin
        checks++;
        if (prod_ready !== 1'b0) begin
          errors++;
          $display("FAIL random_ready_in_hold: prod_ready=%b expected 0", prod_ready);
        end
      end
      if (rf) begin
        checks++;
        if (q_data.size() == 0) begin
          errors++;
          $display("FAIL random_extra_result: data=%h with no group pending", acc_data);
        end else begin
          if (acc_data !== q_data[0] || acc_overflow !== q_ovf[0] || acc_count !== q_cnt[0]) begin
            errors++;
            $display("FAIL random_result: got data=%h ovf=%b count=%0d, expected data=%h ovf=%b count=%0d",
                     acc_data, acc_overflow, acc_count, q_data[0], q_ovf[0], q_cnt[0]);
          end
          void'(q_data.pop_front());
          void'(q_ovf.pop_front());
          void'(q_cnt.pop_front());
          results++;
        end
      end
      if (bf) begin
        beats++;
        m_sum = open ? m_sum + 128'(prod_data) : 128'(prod_data);
        m_n   = open ? m_n + 1 : 1;
        open  = 1;
        if (prod_last) begin
          q_data.push_back(m_sum[ACC_W-1:0]);
          q_ovf.push_back(m_sum >= (128'd1 << ACC_W));
          q_cnt.push_back((m_n > 65535) ? 16'hFFFF : 16'(m_n));
          open = 0;
          groups++;
        end
      end
      step();
      cycles++;
    end
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    checks++;
    if (results != groups || groups == 0) begin
      errors++;
      $display("FAIL random_result_count: results=%0d expected groups=%0d", results, groups);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_clear();
    test_async_reset_hold();
    test_count_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
